gc_ocimem_engine: RTL



---
 rtl/gc_ocimem_pkg.sv | 18 +
 rtl/gc_ocimem_ram.sv | 21 ++
 rtl/gc_ocimem_engine.sv | 134 +++++++++++++
 3 files changed

// File: rtl/gc_ocimem_pkg.sv
// Shared types and jdo field positions for the on-chip debug memory engine.
package gc_ocimem_pkg;
  localparam int DATA_W        = 32;
  localparam int JDO_W         = 38;
  localparam int JDO_RD_BIT    = 34;
  localparam int JDO_CLR_BIT   = 35;
  localparam int JDO_ADDR_LSB  = 26;
  localparam int JDO_WDATA_LSB = 3;

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_CAPT, WR} ocimem_state_e;

  // One-hot view of the JTAG command that won arbitration this cycle.
  typedef struct packed {
    logic load;
    logic wr;
    logic rd;
  } jtag_cmd_t;
endpackage

// File: rtl/gc_ocimem_ram.sv
// Synchronous debug RAM: one write port, one read port, 1-cycle read latency.
module gc_ocimem_ram
  import gc_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/gc_ocimem_engine.sv
// JTAG-driven debug memory engine with optional CPU slave port.
// Define GC_OCIMEM_CPU_PORT_EN to enable the avs_* slave; otherwise it is inert.
module gc_ocimem_engine
  import gc_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest
);
  ocimem_state_e     state, state_nxt;
  jtag_cmd_t         cmd;
  logic              any_pulse, drop;
  logic [ADDR_W-1:0] mon_a_reg;
  logic [DATA_W-1:0] wdata_q, ram_rdata, ram_wdata;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic              cpu_wr_gnt, cpu_rd_gnt, cpu_rd_pend;
  logic              jdo_unused;

  assign jdo_unused = ^{jdo[JDO_W-1:JDO_CLR_BIT+1], jdo[JDO_WDATA_LSB-1:0]};

  // Arbitration (a > b > no_action) and next state; anything not accepted is an error.
  always_comb begin
    any_pulse = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    cmd       = '0;
    drop      = any_pulse;
    if (state == IDLE) begin
      cmd.load = take_action_ocimem_a;
      cmd.wr   = take_action_ocimem_b & ~take_action_ocimem_a;
      cmd.rd   = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
      drop     = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a)) |
                 (take_action_ocimem_b & take_no_action_ocimem_a);
    end
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd.rd || (cmd.load && jdo[JDO_RD_BIT])) state_nxt = RD_ISSUE;
        else if (cmd.wr)                             state_nxt = WR;
      end
      RD_ISSUE: state_nxt = RD_CAPT;
      RD_CAPT:  state_nxt = IDLE;
      WR:       state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      mon_a_reg     <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
      wdata_q       <= '0;
    end else begin
      state         <= state_nxt;
      monitor_error <= (monitor_error & ~(cmd.load & jdo[JDO_CLR_BIT])) | drop;
      if (cmd.load)
        mon_a_reg <= jdo[JDO_ADDR_LSB +: ADDR_W];
      else if (state == WR || state == RD_CAPT)
        mon_a_reg <= mon_a_reg + ADDR_W'(1);
      // Write data is captured with the pulse so jdo may move on afterwards.
      if (cmd.wr) wdata_q <= jdo[JDO_WDATA_LSB +: DATA_W];
      if (state == RD_CAPT) MonDReg <= ram_rdata;
      if (cmd != '0)
        monitor_ready <= 1'b0;
      else if (state != RD_ISSUE)
        monitor_ready <= 1'b1;
    end
  end

`ifdef GC_OCIMEM_CPU_PORT_EN
  logic busy;
  assign busy       = (state != IDLE) | any_pulse;
  assign cpu_wr_gnt = avs_write & ~busy & ~cpu_rd_pend & ~reset;
  assign cpu_rd_gnt = avs_read & ~avs_write & ~busy & ~cpu_rd_pend;

  always_ff @(posedge clk) begin
    if (reset) cpu_rd_pend <= 1'b0;
    else       cpu_rd_pend <= cpu_rd_gnt;
  end

  // Reads stall the grant cycle and complete on the following one.
  always_comb begin
    avs_waitrequest = 1'b0;
    if (!reset) begin
      if (avs_write)     avs_waitrequest = busy | cpu_rd_pend;
      else if (avs_read) avs_waitrequest = ~cpu_rd_pend;
    end
  end
  assign avs_readdata = cpu_rd_pend ? ram_rdata : '0;
`else
  logic cpu_unused;
  assign cpu_unused      = ^{avs_read, avs_write, avs_writedata};
  assign cpu_wr_gnt      = 1'b0;
  assign cpu_rd_gnt      = 1'b0;
  assign cpu_rd_pend     = 1'b0;
  assign avs_waitrequest = 1'b0;
  assign avs_readdata    = '0;
`endif

  // JTAG and CPU never own a RAM port in the same cycle: CPU grants need IDLE.
  always_comb begin
    ram_we    = ~reset & ((state == WR) | cpu_wr_gnt);
    ram_waddr = (state == WR) ? mon_a_reg : avs_address;
    ram_wdata = (state == WR) ? wdata_q : avs_writedata;
    ram_re    = (state == RD_ISSUE) | cpu_rd_gnt;
    ram_raddr = (state == RD_ISSUE) ? mon_a_reg : avs_address;
  end

  gc_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );
endmodule
